// File: rtl/demorgan_pkg.sv
// Shared sizes, FSM states, response bit positions and the golden gate function
// for the De Morgan sweep controller.
package demorgan_pkg;

   localparam int unsigned NUM_VEC  = 4;
   localparam int unsigned VEC_W    = 2;
   localparam int unsigned RESP_W   = 6;
   localparam int unsigned FCNT_W   = 3;
   localparam int unsigned SETTLE_W = 4;

   // resp[5:0] = {nA, nB, AnandB, nAornB, nAorB, nAandnB}
   localparam int unsigned R_NA     = 5;
   localparam int unsigned R_NB     = 4;
   localparam int unsigned R_ANANDB = 3;
   localparam int unsigned R_NAORNB = 2;
   localparam int unsigned R_NAORB  = 1;
   localparam int unsigned R_NANDNB = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      FIN    = 3'd4
   } state_e;

   function automatic logic [RESP_W-1:0] golden_resp(input logic a, input logic b);
      logic [RESP_W-1:0] r;
      r           = '0;
      r[R_NA]     = ~a;
      r[R_NB]     = ~b;
      r[R_ANANDB] = ~(a & b);
      r[R_NAORNB] = ~a | ~b;
      r[R_NAORB]  = ~(a | b);
      r[R_NANDNB] = ~a & ~b;
      return r;
   endfunction

endpackage

// File: rtl/demorgan_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and its environment (gate block + host).
interface demorgan_sweep_ctrl_if #(
   parameter int unsigned CNT_W = 4
);
   import demorgan_pkg::*;

   logic                start;
   logic                a_out;
   logic                b_out;
   logic                nA_in;
   logic                nB_in;
   logic                nAandnB_in;
   logic                AnandB_in;
   logic                nAorB_in;
   logic                nAornB_in;
   logic                busy;
   logic                done;
   logic                pass;
   logic [NUM_VEC-1:0]  err_mask;
   logic [CNT_W-1:0]    err_count;
   logic [VEC_W-1:0]    first_fail_idx;
   logic [RESP_W-1:0]   first_fail_resp;

   modport master (
      input  start, nA_in, nB_in, nAandnB_in, AnandB_in, nAorB_in, nAornB_in,
      output a_out, b_out, busy, done, pass, err_mask, err_count,
             first_fail_idx, first_fail_resp
   );

   modport slave (
      output start, nA_in, nB_in, nAandnB_in, AnandB_in, nAorB_in, nAornB_in,
      input  a_out, b_out, busy, done, pass, err_mask, err_count,
             first_fail_idx, first_fail_resp
   );

endinterface

// File: rtl/demorgan_checker.sv
// Combinational check of one sampled gate response: four golden checks plus the
// two De Morgan identities, one fail bit per response bit, and their popcount.
module demorgan_checker
   import demorgan_pkg::*;
(
   input  logic              a_i,
   input  logic              b_i,
   input  logic [RESP_W-1:0] resp_i,
   output logic [RESP_W-1:0] fail_vec_c,
   output logic [FCNT_W-1:0] fail_cnt_c
);

   logic [RESP_W-1:0] exp_resp;

   // Identity bits take their reference from the partner output, not the golden value.
   always_comb begin
      exp_resp           = golden_resp(a_i, b_i);
      exp_resp[R_NAORNB] = resp_i[R_ANANDB];
      exp_resp[R_NANDNB] = resp_i[R_NAORB];
      fail_vec_c         = resp_i ^ exp_resp;
      fail_cnt_c         = '0;
      for (int unsigned i = 0; i < RESP_W; i++) begin
         fail_cnt_c = fail_cnt_c + FCNT_W'(fail_vec_c[i]);
      end
   end

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Sweeps A/B over all four vectors, samples the De Morgan gate block after a settle
// delay and reports pass/fail. Define DEMORGAN_SWEEP_LOG_EN to capture the first failure.
module demorgan_sweep_ctrl
   import demorgan_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   demorgan_sweep_ctrl_if.master sweep_if
);

   localparam int unsigned         SUM_W       = CNT_W + FCNT_W;
   localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   state_e              state_q, state_d;
   logic [VEC_W-1:0]    vec_q, vec_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic                a_q, a_d, b_q, b_d;
   logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [NUM_VEC-1:0]  err_mask_q, err_mask_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;

   logic [RESP_W-1:0]   resp;
   logic [RESP_W-1:0]   fail_vec;
   logic [FCNT_W-1:0]   fail_cnt;
   logic [SUM_W-1:0]    sum;
   logic [CNT_W-1:0]    cnt_sat;

`ifdef DEMORGAN_SWEEP_LOG_EN
   logic [VEC_W-1:0]    ff_idx_q, ff_idx_d;
   logic [RESP_W-1:0]   ff_resp_q, ff_resp_d;
`endif

   assign resp = {sweep_if.nA_in, sweep_if.nB_in, sweep_if.AnandB_in,
                  sweep_if.nAornB_in, sweep_if.nAorB_in, sweep_if.nAandnB_in};

   demorgan_checker u_checker (
      .a_i        (a_q),
      .b_i        (b_q),
      .resp_i     (resp),
      .fail_vec_c (fail_vec),
      .fail_cnt_c (fail_cnt)
   );

   assign sum     = SUM_W'(err_count_q) + SUM_W'(fail_cnt);
   assign cnt_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum);

   // Next-state and register updates.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_mask_d  = err_mask_q;
      err_count_d = err_count_q;
`ifdef DEMORGAN_SWEEP_LOG_EN
      ff_idx_d    = ff_idx_q;
      ff_resp_d   = ff_resp_q;
`endif
      case (state_q)
         IDLE: begin
            if (sweep_if.start) begin
               err_mask_d  = '0;
               err_count_d = '0;
               pass_d      = 1'b0;
               vec_d       = '0;
               busy_d      = 1'b1;
               state_d     = DRIVE;
`ifdef DEMORGAN_SWEEP_LOG_EN
               ff_idx_d    = '0;
               ff_resp_d   = '0;
`endif
            end
         end
         DRIVE: begin
            a_d     = vec_q[1];
            b_d     = vec_q[0];
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - SETTLE_W'(1);
            end
         end
         CHECK: begin
            err_count_d        = cnt_sat;
            err_mask_d[vec_q]  = |fail_vec;
`ifdef DEMORGAN_SWEEP_LOG_EN
            // An empty mask means no earlier vector of this sweep has failed.
            if ((|fail_vec) && (err_mask_q == '0)) begin
               ff_idx_d  = vec_q;
               ff_resp_d = resp;
            end
`endif
            if (vec_q == VEC_W'(NUM_VEC - 1)) begin
               done_d  = 1'b1;
               pass_d  = (err_mask_d == '0);
               state_d = FIN;
            end else begin
               vec_d   = vec_q + VEC_W'(1);
               state_d = DRIVE;
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         cnt_q       <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_mask_q  <= '0;
         err_count_q <= '0;
`ifdef DEMORGAN_SWEEP_LOG_EN
         ff_idx_q    <= '0;
         ff_resp_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_mask_q  <= err_mask_d;
         err_count_q <= err_count_d;
`ifdef DEMORGAN_SWEEP_LOG_EN
         ff_idx_q    <= ff_idx_d;
         ff_resp_q   <= ff_resp_d;
`endif
      end
   end

   assign sweep_if.a_out     = a_q;
   assign sweep_if.b_out     = b_q;
   assign sweep_if.busy      = busy_q;
   assign sweep_if.done      = done_q;
   assign sweep_if.pass      = pass_q;
   assign sweep_if.err_mask  = err_mask_q;
   assign sweep_if.err_count = err_count_q;
`ifdef DEMORGAN_SWEEP_LOG_EN
   assign sweep_if.first_fail_idx  = ff_idx_q;
   assign sweep_if.first_fail_resp = ff_resp_q;
`else
   assign sweep_if.first_fail_idx  = '0;
   assign sweep_if.first_fail_resp = '0;
`endif

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Scoreboard bench for demorgan_sweep_ctrl: two instances (settle 1 and 3) each beside
// a configurable gate-block model (correct, AnandB stuck-at-0, all inverted, 2-cycle delay).
module tb_demorgan_sweep_ctrl;

   localparam int M_OK = 0, M_STUCK = 1, M_INV = 2, M_DELAY = 3;
   localparam int S1 = 1, S3 = 3;
   localparam int TO = 200;

   typedef struct {
      logic       pass;
      logic [3:0] mask;
      logic [3:0] cnt;
      logic [1:0] idx;
      logic [5:0] resp;
      int         cyc;
   } exp_t;

   typedef struct packed {
      logic       a, b, busy, done, pass;
      logic [3:0] mask;
      logic [3:0] cnt;
      logic [1:0] idx;
      logic [5:0] resp;
   } obs_t;

   logic       clk, rst_n;
   int         edge_cnt = 0;
   int         checks = 0, errors = 0;
   int         mode1 = M_OK, mode3 = M_OK;
   logic [1:0] last_vec [2];
   exp_t       sb_q [$];
   logic [1:0] d1_p, d1_q, d3_p, d3_q, src1, src3;
   logic [5:0] r1, r3;

   demorgan_sweep_ctrl_if #(.CNT_W(4)) if1 ();
   demorgan_sweep_ctrl_if #(.CNT_W(4)) if3 ();

   demorgan_sweep_ctrl #(.SETTLE_CYCLES(S1), .CNT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .sweep_if(if1));
   demorgan_sweep_ctrl #(.SETTLE_CYCLES(S3), .CNT_W(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .sweep_if(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Gate block behaviour; resp = {nA, nB, AnandB, nAornB, nAorB, nAandnB}.
   function automatic logic [5:0] gate_fn(input int mode, input logic a, input logic b);
      logic [5:0] r;
      r = {!a, !b, !(a && b), (!a || !b), !(a || b), (!a && !b)};
      if (mode == M_STUCK) r[3] = 1'b0;
      if (mode == M_INV)   r = ~r;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1_p <= 2'b00; d1_q <= 2'b00; d3_p <= 2'b00; d3_q <= 2'b00;
      end else begin
         d1_p <= {if1.a_out, if1.b_out}; d1_q <= d1_p;
         d3_p <= {if3.a_out, if3.b_out}; d3_q <= d3_p;
      end
   end

   always_comb begin
      src1 = (mode1 == M_DELAY) ? d1_q : {if1.a_out, if1.b_out};
      src3 = (mode3 == M_DELAY) ? d3_q : {if3.a_out, if3.b_out};
      r1   = gate_fn(mode1, src1[1], src1[0]);
      r3   = gate_fn(mode3, src3[1], src3[0]);
   end

   assign {if1.nA_in, if1.nB_in, if1.AnandB_in, if1.nAornB_in, if1.nAorB_in, if1.nAandnB_in} = r1;
   assign {if3.nA_in, if3.nB_in, if3.AnandB_in, if3.nAornB_in, if3.nAorB_in, if3.nAandnB_in} = r3;

   function automatic int n_fail(input logic a, input logic b, input logic [5:0] r);
      int n = 0;
      if (r[5] != !a)        n++;
      if (r[4] != !b)        n++;
      if (r[3] != !(a && b)) n++;
      if (r[1] != !(a || b)) n++;
      if (r[2] != r[3])      n++;
      if (r[0] != r[1])      n++;
      return n;
   endfunction

   // A 2-cycle gate delay with settle < 2 means each CHECK sees the previous vector's response.
   function automatic exp_t predict(input int mode, input int settle, input logic [1:0] prev);
      exp_t e;
      int raw = 0;
      int n;
      bit logged = 0;
      logic [1:0] v, src;
      logic [5:0] r;
      e.mask = '0; e.idx = '0; e.resp = '0;
      for (int i = 0; i < 4; i++) begin
         v   = 2'(i);
         src = (mode == M_DELAY && settle < 2) ? ((i == 0) ? prev : 2'(i - 1)) : v;
         r   = gate_fn(mode, src[1], src[0]);
         n   = n_fail(v[1], v[0], r);
         raw += n;
         if (n != 0) begin
            e.mask[i] = 1'b1;
            if (!logged) begin logged = 1; e.idx = v; e.resp = r; end
         end
      end
      e.cnt  = (raw > 15) ? 4'd15 : 4'(raw);
      e.pass = (e.mask == 4'd0);
      e.cyc  = 1 + 4 * (settle + 2);
`ifndef DEMORGAN_SWEEP_LOG_EN
      e.idx  = '0;
      e.resp = '0;
`endif
      return e;
   endfunction

   function automatic obs_t snap(input int w);
      obs_t o;
      if (w == 0)
         o = {if1.a_out, if1.b_out, if1.busy, if1.done, if1.pass, if1.err_mask,
              if1.err_count, if1.first_fail_idx, if1.first_fail_resp};
      else
         o = {if3.a_out, if3.b_out, if3.busy, if3.done, if3.pass, if3.err_mask,
              if3.err_count, if3.first_fail_idx, if3.first_fail_resp};
      return o;
   endfunction

   task automatic drive_start(input int w, input logic v);
      if (w == 0) if1.start = v; else if3.start = v;
   endtask

   task automatic run_sweep(input int which, input int mode, input string name);
      exp_t e;
      obs_t o;
      int   t0;
      bit   seen = 0;
      if (which == 0) mode1 = mode; else mode3 = mode;
      sb_q.push_back(predict(mode, (which != 0) ? S3 : S1, last_vec[which]));
      @(posedge clk); #1;
      drive_start(which, 1'b1);
      @(posedge clk); #1;
      drive_start(which, 1'b0);
      t0 = edge_cnt;
      o  = snap(which);
      checks++;
      if (o.busy !== 1'b1) begin errors++; $display("FAIL %s busy_cycle1: got %b exp 1", name, o.busy); end
      for (int k = 0; k < TO && !seen; k++) begin
         o = snap(which);
         if (o.done === 1'b1) seen = 1;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done_timeout: got no done within %0d cycles", name, TO);
         void'(sb_q.pop_front());
         return;
      end
      e = sb_q.pop_front();
      checks += 6;
      if (edge_cnt - t0 + 1 != e.cyc) begin errors++; $display("FAIL %s done_cycle: got %0d exp %0d", name, edge_cnt - t0 + 1, e.cyc); end
      if (o.pass !== e.pass) begin errors++; $display("FAIL %s pass: got %b exp %b", name, o.pass, e.pass); end
      if (o.mask !== e.mask) begin errors++; $display("FAIL %s err_mask: got %b exp %b", name, o.mask, e.mask); end
      if (o.cnt !== e.cnt)   begin errors++; $display("FAIL %s err_count: got %0d exp %0d", name, o.cnt, e.cnt); end
      if (o.idx !== e.idx)   begin errors++; $display("FAIL %s first_fail_idx: got %0d exp %0d", name, o.idx, e.idx); end
      if (o.resp !== e.resp) begin errors++; $display("FAIL %s first_fail_resp: got %b exp %b", name, o.resp, e.resp); end
      @(posedge clk); #1;
      o = snap(which);
      checks++;
      if ({o.done, o.busy, o.pass} !== {1'b0, 1'b0, e.pass}) begin
         errors++;
         $display("FAIL %s after_fin done/busy/pass: got %b%b%b exp 00%b", name, o.done, o.busy, o.pass, e.pass);
      end
      last_vec[which] = 2'b11;
   endtask

   task automatic test_reset();
      obs_t o;
      rst_n = 1'b0;
      if1.start = 1'b0;
      if3.start = 1'b0;
      last_vec[0] = 2'b00;
      last_vec[1] = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         o = snap(w);
         checks++;
         if (o !== '0) begin errors++; $display("FAIL reset_state dut%0d: got %h exp 0", w, o); end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();      run_sweep(0, M_OK,    "basic");    endtask
   task automatic test_stuck();      run_sweep(0, M_STUCK, "stuck");    endtask
   task automatic test_inverted();   run_sweep(0, M_INV,   "inverted"); endtask

   task automatic test_settle();
      run_sweep(1, M_DELAY, "settle3_delay");
      run_sweep(0, M_DELAY, "settle1_delay");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      obs_t o;
      int   ndone = 0;
      int   first = -1;
      mode1 = M_OK;
      sb_q.push_back(predict(M_OK, S1, last_vec[0]));
      @(posedge clk); #1;
      drive_start(0, 1'b1);
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         drive_start(0, cyc == 5);
         o = snap(0);
         if (o.done === 1'b1) begin ndone++; if (first < 0) first = cyc; end
         @(posedge clk); #1;
      end
      drive_start(0, 1'b0);
      e = sb_q.pop_front();
      o = snap(0);
      checks += 4;
      if (ndone != 1)        begin errors++; $display("FAIL b2b done_pulses: got %0d exp 1", ndone); end
      if (first != e.cyc)    begin errors++; $display("FAIL b2b done_cycle: got %0d exp %0d", first, e.cyc); end
      if (o.pass !== e.pass) begin errors++; $display("FAIL b2b pass: got %b exp %b", o.pass, e.pass); end
      if ({o.mask, o.cnt} !== {e.mask, e.cnt}) begin
         errors++;
         $display("FAIL b2b mask/count: got %b/%0d exp %b/%0d", o.mask, o.cnt, e.mask, e.cnt);
      end
      last_vec[0] = 2'b11;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int   ndone = 0;
      mode1 = M_STUCK;
      sb_q.push_back(predict(M_STUCK, S1, last_vec[0]));
      @(posedge clk); #1;
      drive_start(0, 1'b1);
      @(posedge clk); #1;
      drive_start(0, 1'b0);
      repeat (6) begin @(posedge clk); #1; end
      o = snap(0);
      checks++;
      if (o.busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy_before: got %b exp 1", o.busy); end
      #2 rst_n = 1'b0;
      #1;
      sb_q.delete();
      for (int w = 0; w < 2; w++) begin
         o = snap(w);
         checks++;
         if (o !== '0) begin errors++; $display("FAIL rst_mid async_clear dut%0d: got %h exp 0", w, o); end
      end
      repeat (2) begin
         @(posedge clk); #1;
         o = snap(0);
         if (o.done === 1'b1) ndone++;
      end
      repeat (12) begin
         if (if1.done === 1'b1) ndone++;
         @(posedge clk); #1;
         if (rst_n === 1'b0) rst_n = 1'b1;
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL rst_mid no_done: got %0d pulses exp 0", ndone); end
      last_vec[0] = 2'b00;
      last_vec[1] = 2'b00;
      run_sweep(0, M_OK, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stuck();
      test_inverted();
      test_settle();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
